// File: rtl/frame_scanout_pkg.sv
// Shared constants for the frame scanout block: framebuffer geometry,
// 640x480@60 VGA timing, FSM encoding and the framebuffer address helper.
package frame_scanout_pkg;

    // Framebuffer geometry; each stored pixel covers a (1<<SCALE_LOG2)^2 screen block
    localparam logic [9:0]  FB_W       = 10'd160;
    localparam logic [9:0]  FB_H       = 10'd120;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned FB_DEPTH   = 19200;
    localparam int unsigned FB_AW      = 15;
    localparam logic [14:0] FB_LAST    = 15'd19199;

    // Horizontal timing in pixel clocks
    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_TOT  = 10'd800;

    // Vertical timing in lines
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_TOT  = 10'd525;

    // FSM encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef logic [2:0] colour_t;

    // y*160 + x without a multiplier: (y<<7) + (y<<5) + x, in 15 bits
    function automatic logic [FB_AW-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
        logic [FB_AW-1:0] w_x;
        logic [FB_AW-1:0] w_y;
        w_x = {5'd0, x};
        w_y = {5'd0, y};
        return (w_y << 7) + (w_y << 5) + w_x;
    endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// Pixel write port: the drawing engine (master) plots pixels, the scanout
// block (slave) reports when it is accepting writes.
interface frame_scanout_if;
    import frame_scanout_pkg::*;

    logic [9:0] wr_x;
    logic [9:0] wr_y;
    colour_t    wr_colour;
    logic       wr_plot;
    logic       ready;

    modport master (
        output wr_x,
        output wr_y,
        output wr_colour,
        output wr_plot,
        input  ready
    );

    modport slave (
        input  wr_x,
        input  wr_y,
        input  wr_colour,
        input  wr_plot,
        output ready
    );

endinterface

// File: rtl/frame_scanout_fb_ram.sv
// 19200x3 simple dual-port framebuffer: one write port, one registered read
// port. No reset on the array or read register so it maps onto M4K blocks.
// A read and write of the same address in one cycle returns the old data.
module fb_ram
    import frame_scanout_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_we,
    input  logic [FB_AW-1:0] i_waddr,
    input  colour_t          i_wdata,
    input  logic             i_re,
    input  logic [FB_AW-1:0] i_raddr,
    output colour_t          o_rdata
);

    colour_t r_mem [0:FB_DEPTH-1];

    // Write and registered read; non-blocking update gives read-before-write
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// VGA scanout of a 160x120x3 framebuffer at 640x480, each stored pixel
// replicated into a 4x4 screen block. After reset the framebuffer is cleared
// one word per cycle before pixel writes are accepted.
module frame_scanout
    import frame_scanout_pkg::*;
(
    input  logic                 i_clock,
    input  logic                 i_reset,
    frame_scanout_if.slave       io_wr,
    output logic [7:0]           o_vga_r,
    output logic [7:0]           o_vga_g,
    output logic [7:0]           o_vga_b,
    output logic                 o_vga_hs,
    output logic                 o_vga_vs,
    output logic                 o_vga_blank_n,
    output logic                 o_frame_start
);

    logic [0:0]       r_state;
    logic [FB_AW-1:0] r_clr_addr;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;

    // Stage 1: aligned with the RAM read data
    logic             r_vis1;
    logic             r_hsync1;
    logic             r_vsync1;
    logic             r_fs1;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_visible;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_fs;
    logic [9:0]       w_fb_x;
    logic [9:0]       w_fb_y;
    logic [FB_AW-1:0] w_raddr;
    logic             w_in_range;
    logic             w_we;
    logic [FB_AW-1:0] w_waddr;
    colour_t          w_wdata;
    colour_t          w_rdata;

    assign io_wr.ready = (r_state == ST_RUN);

    // Clear sequencer: sweep every address once, then hand over to pixel writes
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_addr == FB_LAST) begin
                r_state <= ST_RUN;
            end else begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    // Write port mux: zeros while clearing, in-range plots while running
    always_comb begin
        w_in_range = (io_wr.wr_x < FB_W) && (io_wr.wr_y < FB_H);
        w_we       = 1'b0;
        w_waddr    = r_clr_addr;
        w_wdata    = 3'b000;
        if (r_state == ST_CLEAR) begin
            w_we = 1'b1;
        end else if (io_wr.wr_plot && w_in_range) begin
            w_we    = 1'b1;
            w_waddr = fb_addr(io_wr.wr_x, io_wr.wr_y);
            w_wdata = io_wr.wr_colour;
        end
    end

    // Raster counters; they run in both states so sync never stops
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h_last) begin
            r_hcount <= '0;
            r_vcount <= w_v_last ? 10'd0 : r_vcount + 1'b1;
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    // Stage 0 decode straight from the counters
    always_comb begin
        w_h_last  = (r_hcount == H_TOT - 10'd1);
        w_v_last  = (r_vcount == V_TOT - 10'd1);
        w_visible = (r_hcount < H_VIS) && (r_vcount < V_VIS);
        w_hsync   = (r_hcount >= H_VIS + H_FP) && (r_hcount < H_VIS + H_FP + H_SYNC);
        w_vsync   = (r_vcount >= V_VIS + V_FP) && (r_vcount < V_VIS + V_FP + V_SYNC);
        w_fs      = (r_hcount == 10'd0) && (r_vcount == 10'd0);
        w_fb_x    = r_hcount >> SCALE_LOG2;
        w_fb_y    = r_vcount >> SCALE_LOG2;
        w_raddr   = fb_addr(w_fb_x, w_fb_y);
    end

    fb_ram u_fb_ram (
        .i_clock (i_clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_visible),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Stage 1: carry timing alongside the RAM read; blank everything while clearing
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vis1   <= 1'b0;
            r_hsync1 <= 1'b0;
            r_vsync1 <= 1'b0;
            r_fs1    <= 1'b0;
        end else begin
            r_vis1   <= w_visible && (r_state == ST_RUN);
            r_hsync1 <= w_hsync;
            r_vsync1 <= w_vsync;
            r_fs1    <= w_fs;
        end
    end

    // Stage 2: registered outputs; syncs are active-low on the pins
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_vga_r       <= 8'h00;
            o_vga_g       <= 8'h00;
            o_vga_b       <= 8'h00;
            o_vga_hs      <= 1'b1;
            o_vga_vs      <= 1'b1;
            o_vga_blank_n <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_vga_r       <= (r_vis1 && w_rdata[2]) ? 8'hFF : 8'h00;
            o_vga_g       <= (r_vis1 && w_rdata[1]) ? 8'hFF : 8'h00;
            o_vga_b       <= (r_vis1 && w_rdata[0]) ? 8'hFF : 8'h00;
            o_vga_hs      <= ~r_hsync1;
            o_vga_vs      <= ~r_vsync1;
            o_vga_blank_n <= r_vis1;
            o_frame_start <= r_fs1;
        end
    end

endmodule
